// File: rtl/reg_read_bank.sv
// Register bank with write-to-read bypass and A/B operand latches.
// Register 0 is hardwired to zero; SP comes out of reset preloaded.
module reg_read_bank #(
    parameter int DATA_W   = 32,
    parameter int SP_INDEX = 29,
    parameter int SP_RESET = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    input  logic              load_a,
    input  logic              load_b,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out
);

    logic [DATA_W-1:0] regs [1:31];
    logic [DATA_W-1:0] rf   [0:31];
    logic              wr_en;

    assign wr_en = reg_write && (write_reg != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wr_en && (write_reg == 5'(i))) begin
                    regs[i] <= write_data;
                end
            end
        end
    end

    // Flat view with slot 0 tied to zero so reads need no special range.
    always_comb begin
        rf[0] = '0;
        for (int i = 1; i < 32; i++) begin
            rf[i] = regs[i];
        end
    end

    always_comb begin
        read_data1 = rf[read_reg1];
        read_data2 = rf[read_reg2];
        if (wr_en && (write_reg == read_reg1)) begin
            read_data1 = write_data;
        end
        if (wr_en && (write_reg == read_reg2)) begin
            read_data2 = write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_out <= '0;
            b_out <= '0;
        end else begin
            if (load_a) begin
                a_out <= read_data1;
            end
            if (load_b) begin
                b_out <= read_data2;
            end
        end
    end

endmodule

// File: tb/tb_reg_read_bank.sv
// Directed bench for reg_read_bank: reset, bypass, r0, latches,
// async reset between edges and reset during a write.
module tb_reg_read_bank;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic        load_a;
    logic        load_b;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] a_out;
    logic [31:0] b_out;

    int checks   = 0;
    int failures = 0;

    reg_read_bank #(
        .DATA_W  (32),
        .SP_INDEX(29),
        .SP_RESET(227)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reg_write (reg_write),
        .write_reg (write_reg),
        .write_data(write_data),
        .read_reg1 (read_reg1),
        .read_reg2 (read_reg2),
        .load_a    (load_a),
        .load_b    (load_b),
        .read_data1(read_data1),
        .read_data2(read_data2),
        .a_out     (a_out),
        .b_out     (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write  = 1'b0;
        write_reg  = 5'd0;
        write_data = 32'h0;
        load_a     = 1'b0;
        load_b     = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        read_reg1 = 5'd0;
        read_reg2 = 5'd0;
        idle();

        // async reset before any clock edge
        #2;
        reset = 1'b1;
        read_reg1 = 5'd29;
        read_reg2 = 5'd5;
        #1;
        chk("rst_sp", read_data1, 32'd227);
        chk("rst_r5", read_data2, 32'd0);
        chk("rst_a", a_out, 32'd0);
        chk("rst_b", b_out, 32'd0);
        tick();
        reset = 1'b0;

        // write reg 8, then read and load A
        reg_write  = 1'b1;
        write_reg  = 5'd8;
        write_data = 32'hDEADBEEF;
        tick();
        idle();
        read_reg1 = 5'd8;
        load_a    = 1'b1;
        #1;
        chk("wr8_rd1", read_data1, 32'hDEADBEEF);
        tick();
        chk("wr8_a", a_out, 32'hDEADBEEF);

        // make B nonzero so the r0 test is meaningful
        idle();
        read_reg2 = 5'd8;
        load_b    = 1'b1;
        tick();
        chk("ld_b8", b_out, 32'hDEADBEEF);

        // write to r0 ignored, no bypass
        reg_write  = 1'b1;
        write_reg  = 5'd0;
        write_data = 32'h1234;
        read_reg2  = 5'd0;
        load_b     = 1'b1;
        #1;
        chk("r0_byp", read_data2, 32'd0);
        tick();
        chk("r0_b", b_out, 32'd0);
        idle();
        read_reg1 = 5'd0;
        #1;
        chk("r0_hold", read_data1, 32'd0);

        // same-cycle write and load, both ports same index
        reg_write  = 1'b1;
        write_reg  = 5'd9;
        write_data = 32'h55;
        read_reg1  = 5'd9;
        read_reg2  = 5'd9;
        load_a     = 1'b1;
        #1;
        chk("byp_rd1", read_data1, 32'h55);
        chk("byp_rd2", read_data2, 32'h55);
        tick();
        chk("byp_a", a_out, 32'h55);
        idle();
        #1;
        chk("r9_rd1", read_data1, 32'h55);
        chk("r9_rd2", read_data2, 32'h55);

        // A holds while its source is rewritten
        read_reg1 = 5'd8;
        load_a    = 1'b1;
        tick();
        chk("a_ld8", a_out, 32'hDEADBEEF);
        idle();
        reg_write  = 1'b1;
        write_reg  = 5'd8;
        write_data = 32'h1;
        tick();
        idle();
        chk("a_hold", a_out, 32'hDEADBEEF);
        #1;
        chk("r8_new", read_data1, 32'h1);

        // load A and B together
        read_reg1 = 5'd9;
        read_reg2 = 5'd8;
        load_a    = 1'b1;
        load_b    = 1'b1;
        tick();
        chk("ab_a", a_out, 32'h55);
        chk("ab_b", b_out, 32'h1);

        // overwrite SP, then async reset between edges
        idle();
        reg_write  = 1'b1;
        write_reg  = 5'd29;
        write_data = 32'h10;
        tick();
        idle();
        read_reg1 = 5'd29;
        read_reg2 = 5'd9;
        #1;
        chk("sp_wr", read_data1, 32'h10);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_sp", read_data1, 32'd227);
        chk("ar_r9", read_data2, 32'd0);
        chk("ar_a", a_out, 32'd0);
        chk("ar_b", b_out, 32'd0);

        // write and load attempted while reset held are lost
        tick();
        reg_write  = 1'b1;
        write_reg  = 5'd9;
        write_data = 32'h77;
        load_a     = 1'b1;
        tick();
        idle();
        #1;
        chk("rw_r9", read_data2, 32'd0);
        chk("rw_a", a_out, 32'd0);

        // operation resumes after reset release
        reset = 1'b0;
        reg_write  = 1'b1;
        write_reg  = 5'd9;
        write_data = 32'h77;
        tick();
        idle();
        #1;
        chk("post_r9", read_data2, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
